// File: rtl/jtdd_gfx_pkg.sv
// Shared types and constants for the Double Dragon graphics ROM responder.
// Slot indices double as the arbitration priority, lowest index first.
package jtdd_gfx_pkg;

    localparam int ROM_AW    = 22;
    localparam int NUM_SLOTS = 3;

    localparam int SLOT_CHAR = 0;
    localparam int SLOT_SCR  = 1;
    localparam int SLOT_OBJ  = 2;

    typedef logic [1:0] slot_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        WAIT_RDY
    } arb_state_t;

    typedef struct packed {
        logic [ROM_AW-1:0] tag;
        logic [15:0]       data;
    } slot_fill_t;

    // Fixed priority: the lowest pending slot index wins.
    function automatic slot_idx_t prio_sel(input logic [NUM_SLOTS-1:0] pend);
        slot_idx_t s;
        s = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (pend[i]) s = slot_idx_t'(i);
        end
        return s;
    endfunction

endpackage

// File: rtl/jtdd_rom_slot.sv
// One-entry tagged cache for a single video ROM requester.
// hit is a pure compare so an address change drops it in the same cycle.
module jtdd_rom_slot
    import jtdd_gfx_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ROM_AW-1:0] req_addr,
    input  logic              fill_en,
    input  slot_fill_t        fill,
    output logic              hit,
    output logic [15:0]       data
);

    logic [ROM_AW-1:0] tag;
    logic              valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag   <= '0;
            data  <= '0;
            valid <= 1'b0;
        end else if (fill_en) begin
            tag   <= fill.tag;
            data  <= fill.data;
            valid <= 1'b1;
        end
    end

    assign hit = valid && (tag == req_addr);

endmodule

// File: rtl/jtdd_gfx_rom_arb.sv
// Graphics ROM responder: three cached requesters sharing one SDRAM read port.
// A fill always tags with the address that was issued, so stale data never hits.
module jtdd_gfx_rom_arb
    import jtdd_gfx_pkg::*;
#(
    parameter logic [ROM_AW-1:0] CHAR_OFFSET = 22'h00_0000,
    parameter logic [ROM_AW-1:0] SCR_OFFSET  = 22'h01_0000,
    parameter logic [ROM_AW-1:0] OBJ_OFFSET  = 22'h04_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       char_addr,
    output logic [7:0]        char_data,
    output logic              char_ok,
    input  logic [16:0]       scr_addr,
    output logic [15:0]       scr_data,
    output logic              scr_ok,
    input  logic [18:0]       obj_addr,
    output logic [15:0]       obj_data,
    output logic              obj_ok,
    output logic [ROM_AW-1:0] sdram_addr,
    output logic              sdram_req,
    input  logic              sdram_ack,
    input  logic              sdram_rdy,
    input  logic [15:0]       sdram_dout
);

    logic [NUM_SLOTS-1:0][ROM_AW-1:0] req_addr;
    logic [NUM_SLOTS-1:0][15:0]       slot_data;
    logic [NUM_SLOTS-1:0]             hit;
    logic [NUM_SLOTS-1:0]             pending;
    logic [NUM_SLOTS-1:0]             fill_en;
    slot_fill_t                       fill;

    arb_state_t        state, state_nxt;
    slot_idx_t         sel, sel_nxt, grant;
    logic [ROM_AW-1:0] issue_addr, issue_nxt;
    logic              req_nxt;

    // Char ROM is byte addressed; the word holds both bytes.
    assign req_addr[SLOT_CHAR] = CHAR_OFFSET + ROM_AW'(char_addr[15:1]);
    assign req_addr[SLOT_SCR]  = SCR_OFFSET  + ROM_AW'(scr_addr);
    assign req_addr[SLOT_OBJ]  = OBJ_OFFSET  + ROM_AW'(obj_addr);

    assign fill = '{tag: issue_addr, data: sdram_dout};

    genvar g;
    generate
        for (g = 0; g < NUM_SLOTS; g++) begin : g_slot
            jtdd_rom_slot u_slot (
                .clk      (clk),
                .rst_n    (rst_n),
                .req_addr (req_addr[g]),
                .fill_en  (fill_en[g]),
                .fill     (fill),
                .hit      (hit[g]),
                .data     (slot_data[g])
            );
        end
    endgenerate

    assign pending = ~hit;
    assign grant   = prio_sel(pending);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sel        <= '0;
            issue_addr <= '0;
            sdram_req  <= 1'b0;
        end else begin
            state      <= state_nxt;
            sel        <= sel_nxt;
            issue_addr <= issue_nxt;
            sdram_req  <= req_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        issue_nxt = issue_addr;
        req_nxt   = sdram_req;
        fill_en   = '0;
        case (state)
            IDLE: begin
                if (|pending) begin
                    sel_nxt   = grant;
                    issue_nxt = req_addr[grant];
                    req_nxt   = 1'b1;
                    state_nxt = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (sdram_ack) begin
                    req_nxt = 1'b0;
                    // ack and rdy together: accept and fill in one step
                    if (sdram_rdy) begin
                        fill_en   = NUM_SLOTS'(1) << sel;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = WAIT_RDY;
                    end
                end
            end
            WAIT_RDY: begin
                if (sdram_rdy) begin
                    fill_en   = NUM_SLOTS'(1) << sel;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign sdram_addr = issue_addr;

    assign char_ok   = hit[SLOT_CHAR];
    assign scr_ok    = hit[SLOT_SCR];
    assign obj_ok    = hit[SLOT_OBJ];
    assign char_data = char_addr[0] ? slot_data[SLOT_CHAR][15:8] : slot_data[SLOT_CHAR][7:0];
    assign scr_data  = slot_data[SLOT_SCR];
    assign obj_data  = slot_data[SLOT_OBJ];

endmodule

// File: tb/tb_jtdd_gfx_rom_arb.sv
// Bench for jtdd_gfx_rom_arb: directed scenarios then a random phase, all
// checked every cycle against a transaction-level cache model.
module tb_jtdd_gfx_rom_arb;

    localparam logic [21:0] CHAR_OFF = 22'h00_0000;
    localparam logic [21:0] SCR_OFF  = 22'h01_0000;
    localparam logic [21:0] OBJ_OFF  = 22'h3C_0000;

    logic        clk, rst_n;
    logic [15:0] char_addr;
    logic [7:0]  char_data;
    logic        char_ok;
    logic [16:0] scr_addr;
    logic [15:0] scr_data;
    logic        scr_ok;
    logic [18:0] obj_addr;
    logic [15:0] obj_data;
    logic        obj_ok;
    logic [21:0] sdram_addr;
    logic        sdram_req, sdram_ack, sdram_rdy;
    logic [15:0] sdram_dout;

    jtdd_gfx_rom_arb #(
        .CHAR_OFFSET (CHAR_OFF),
        .SCR_OFFSET  (SCR_OFF),
        .OBJ_OFFSET  (OBJ_OFF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .char_addr  (char_addr),
        .char_data  (char_data),
        .char_ok    (char_ok),
        .scr_addr   (scr_addr),
        .scr_data   (scr_data),
        .scr_ok     (scr_ok),
        .obj_addr   (obj_addr),
        .obj_data   (obj_data),
        .obj_ok     (obj_ok),
        .sdram_addr (sdram_addr),
        .sdram_req  (sdram_req),
        .sdram_ack  (sdram_ack),
        .sdram_rdy  (sdram_rdy),
        .sdram_dout (sdram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    // Model: per-slot cached word plus the single outstanding transaction.
    logic [2:0]  m_valid;
    logic [21:0] m_tag  [3];
    logic [15:0] m_data [3];
    bit          m_busy, m_acked;
    int          m_slot;
    logic [21:0] m_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [21:0] want(input int s);
        logic [21:0] w;
        case (s)
            0:       w = CHAR_OFF + {7'd0, char_addr[15:1]};
            1:       w = SCR_OFF + {5'd0, scr_addr};
            default: w = OBJ_OFF + {3'd0, obj_addr};
        endcase
        return w;
    endfunction

    function automatic bit mhit(input int s);
        return m_valid[s] && (m_tag[s] == want(s));
    endfunction

    task automatic mdl_reset();
        m_valid = '0;
        for (int s = 0; s < 3; s++) begin
            m_tag[s]  = '0;
            m_data[s] = '0;
        end
        m_busy  = 0;
        m_acked = 0;
        m_slot  = 0;
        m_addr  = '0;
    endtask

    task automatic mdl_fill();
        m_valid[m_slot] = 1'b1;
        m_tag[m_slot]   = m_addr;
        m_data[m_slot]  = sdram_dout;
        m_busy          = 0;
    endtask

    // Advance the model by one clock edge using the inputs the DUT sampled.
    task automatic mdl_step();
        bit found;
        if (!rst_n) begin
            mdl_reset();
        end else if (!m_busy) begin
            found = 0;
            for (int s = 0; s < 3; s++) begin
                if (!found && !mhit(s)) begin
                    found   = 1;
                    m_busy  = 1;
                    m_acked = 0;
                    m_slot  = s;
                    m_addr  = want(s);
                end
            end
        end else if (!m_acked) begin
            if (sdram_ack) begin
                m_acked = 1;
                if (sdram_rdy) mdl_fill();
            end
        end else if (sdram_rdy) begin
            mdl_fill();
        end
    endtask

    task automatic check_all();
        logic [7:0] cb;
        cb = char_addr[0] ? m_data[0][15:8] : m_data[0][7:0];
        chk("sdram_req", 32'(sdram_req), 32'(m_busy && !m_acked));
        if (m_busy && !m_acked) chk("sdram_addr", 32'(sdram_addr), 32'(m_addr));
        chk("char_ok", 32'(char_ok), 32'(mhit(0)));
        chk("scr_ok", 32'(scr_ok), 32'(mhit(1)));
        chk("obj_ok", 32'(obj_ok), 32'(mhit(2)));
        chk("char_data", 32'(char_data), 32'(cb));
        chk("scr_data", 32'(scr_data), 32'(m_data[1]));
        chk("obj_data", 32'(obj_data), 32'(m_data[2]));
    endtask

    task automatic tick();
        @(posedge clk);
        mdl_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic wait_req(output logic [21:0] a, output int lat);
        lat = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            lat++;
            if (sdram_req) break;
        end
        chk("req_seen", 32'(sdram_req), 32'(1));
        a = sdram_addr;
    endtask

    task automatic do_ack(input int delay);
        repeat (delay) tick();
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
    endtask

    task automatic do_rdy(input logic [15:0] d);
        sdram_dout = d;
        sdram_rdy  = 1'b1;
        tick();
        sdram_rdy  = 1'b0;
    endtask

    task automatic serve_expect(input string tag, input logic [21:0] exp_a, input int ack_dly);
        logic [21:0] a;
        int lat;
        wait_req(a, lat);
        chk(tag, 32'(a), 32'(exp_a));
        do_ack(ack_dly);
        do_rdy(16'($urandom));
    endtask

    initial begin
        logic [21:0] a, a0;
        int lat;
        logic [15:0] d;

        rst_n = 1'b0;
        char_addr = '0; scr_addr = '0; obj_addr = '0;
        sdram_ack = 1'b0; sdram_rdy = 1'b0; sdram_dout = '0;
        mdl_reset();
        repeat (3) tick();
        chk("rst_req", 32'(sdram_req), 32'(0));
        chk("rst_addr", 32'(sdram_addr), 32'(0));
        chk("rst_ok", 32'({char_ok, scr_ok, obj_ok}), 32'(0));
        chk("rst_data", 32'({char_data, scr_data, obj_data}), 32'(0));
        rst_n = 1'b1;

        // Every slot misses out of reset: served in priority order.
        serve_expect("init_char", CHAR_OFF, 0);
        serve_expect("init_scr", SCR_OFF, 0);
        serve_expect("init_obj", OBJ_OFF, 0);
        tick();
        chk("init_all_ok", 32'({char_ok, scr_ok, obj_ok}), 32'(3'b111));

        // Char miss: 3-clock latency, then odd/even toggle inside the word.
        char_addr = 16'h0003;
        #1 chk("char_ok_drop", 32'(char_ok), 32'(0));
        wait_req(a, lat);
        chk("char_req_lat", 32'(lat), 32'(1));
        chk("char_req_addr", 32'(a), 32'(22'h000001));
        do_ack(0);
        do_rdy(16'hA55A);
        chk("char_ok_3clk", 32'(char_ok), 32'(1));
        chk("char_odd_byte", 32'(char_data), 32'(8'hA5));
        char_addr = 16'h0002;
        #1 chk("char_even_ok", 32'(char_ok), 32'(1));
        chk("char_even_byte", 32'(char_data), 32'(8'h5A));
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("char_no_req", 32'(sdram_req), 32'(0));
        end

        // Simultaneous misses on all three slots.
        char_addr = 16'h1000 + 16'($urandom_range(0, 255));
        scr_addr  = 17'h00100 + 17'($urandom_range(0, 255));
        obj_addr  = 19'h00200 + 19'($urandom_range(0, 255));
        serve_expect("order_char", CHAR_OFF + {7'd0, char_addr[15:1]}, $urandom_range(0, 2));
        serve_expect("order_scr", SCR_OFF + {5'd0, scr_addr}, $urandom_range(0, 2));
        serve_expect("order_obj", OBJ_OFF + {3'd0, obj_addr}, $urandom_range(0, 2));
        tick();
        chk("order_all_ok", 32'({char_ok, scr_ok, obj_ok}), 32'(3'b111));

        // Scroll address moves while its fetch waits for data.
        scr_addr = 17'h00010;
        wait_req(a, lat);
        chk("stale_addr1", 32'(a), 32'(22'h010010));
        do_ack(0);
        scr_addr = 17'h00020;
        do_rdy(16'h1111);
        chk("stale_ok_low", 32'(scr_ok), 32'(0));
        wait_req(a, lat);
        chk("stale_addr2", 32'(a), 32'(22'h010020));
        do_ack(1);
        d = 16'($urandom);
        do_rdy(d);
        chk("stale_ok_high", 32'(scr_ok), 32'(1));
        chk("stale_data", 32'(scr_data), 32'(d));

        // Ack withheld for 10 cycles.
        obj_addr = 19'h12345;
        wait_req(a0, lat);
        chk("hold_addr", 32'(a0), 32'(OBJ_OFF + 22'h012345));
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_req", 32'(sdram_req), 32'(1));
            chk("hold_addr_stable", 32'(sdram_addr), 32'(a0));
            chk("hold_obj_ok", 32'(obj_ok), 32'(0));
        end
        do_ack(0);
        do_rdy(16'($urandom));
        chk("hold_obj_ok_after", 32'(obj_ok), 32'(1));

        // Reset in WAIT_RDY; a late rdy must not fill anything.
        char_addr = 16'h4444;
        wait_req(a, lat);
        do_ack(0);
        rst_n = 1'b0;
        mdl_reset();
        #1 chk("arst_req", 32'(sdram_req), 32'(0));
        chk("arst_ok", 32'({char_ok, scr_ok, obj_ok}), 32'(0));
        tick();
        rst_n = 1'b1;
        sdram_dout = 16'hDEAD;
        sdram_rdy  = 1'b1;
        #1 chk("arst_rel_req", 32'(sdram_req), 32'(0));
        tick();
        sdram_rdy = 1'b0;
        chk("arst_late_rdy_ok", 32'({char_ok, scr_ok, obj_ok}), 32'(0));
        chk("arst_late_rdy_data", 32'(scr_data), 32'(0));
        do_ack(0);
        do_rdy(16'($urandom));
        serve_expect("arst_refill_scr", SCR_OFF + 22'h20, 0);
        serve_expect("arst_refill_obj", OBJ_OFF + 22'h012345, 0);

        // Object offset plus address wraps modulo 2^22.
        obj_addr = 19'h7FFFF;
        wait_req(a, lat);
        chk("wrap_addr", 32'(a), 32'(22'h03FFFF));
        do_ack(0);
        do_rdy(16'hBEEF);
        chk("wrap_ok", 32'(obj_ok), 32'(1));
        chk("wrap_data", 32'(obj_data), 32'(16'hBEEF));

        // Random phase: address churn over a small pool, random/spurious ack and rdy.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) char_addr = 16'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) scr_addr  = 17'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) obj_addr  = 19'h7FFFC + 19'($urandom_range(0, 3));
            sdram_ack  = ($urandom_range(0, 2) == 0);
            sdram_rdy  = ($urandom_range(0, 2) == 0);
            sdram_dout = 16'($urandom);
            tick();
        end
        sdram_ack = 1'b0;
        sdram_rdy = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
